// File: rtl/hazard_ctrl_if.sv
// Stage handshake and hazard-control bundle between the LA32R pipeline stages and hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
);
    logic             ds_valid;
    logic [REG_W-1:0] ds_rj;
    logic [REG_W-1:0] ds_rk;
    logic             ds_use_rj;
    logic             ds_use_rk;
    logic             ds_we;
    logic [REG_W-1:0] ds_waddr;
    logic             ds_is_load;
    logic             ds_br_taken;
    logic             es_allow_in;
    logic             es_go;
    logic             ms_go;
    logic             ws_go;
    logic             ms_load_pending;
    logic             fs_ready;
    logic             ds_stall;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;
    logic             br_flush;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;

    modport master (
        output ds_valid, ds_rj, ds_rk, ds_use_rj, ds_use_rk, ds_we, ds_waddr,
               ds_is_load, ds_br_taken, es_allow_in, es_go, ms_go, ws_go,
               ms_load_pending, fs_ready,
        input  ds_stall, fwd_sel1, fwd_sel2, br_flush, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  ds_valid, ds_rj, ds_rk, ds_use_rj, ds_use_rk, ds_we, ds_waddr,
               ds_is_load, ds_br_taken, es_allow_in, es_go, ms_go, ws_go,
               ms_load_pending, fs_ready,
        output ds_stall, fwd_sel1, fwd_sel2, br_flush, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Interlock/forwarding controller: shadow scoreboard of EXE/MEM/WB destinations driving ID stall,
// operand forwarding selects and branch flush. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic             v;
        logic             we;
        logic [REG_W-1:0] waddr;
        logic             ld;
    } slot_t;

    typedef enum logic {FL_IDLE, FL_PEND} fl_state_t;

    localparam slot_t SLOT_EMPTY = '0;

    slot_t     es_q, ms_q, ws_q;
    slot_t     ds_slot;
    fl_state_t fl_q, fl_next;

    logic       issue;
    logic       stall_c;
    logic       br_resolve;
    logic [1:0] sel1_c, sel2_c;

    function automatic logic hit(input slot_t s, input logic [REG_W-1:0] a);
        return s.v && s.we && (s.waddr != '0) && (s.waddr == a);
    endfunction

    // Newest producer wins: EXE, then MEM, then WB, else register file
    function automatic logic [1:0] pick(input logic use_src, input logic [REG_W-1:0] a,
                                        input slot_t es, input slot_t ms, input slot_t ws);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_src) begin
            if (hit(es, a))      sel = 2'd1;
            else if (hit(ms, a)) sel = 2'd2;
            else if (hit(ws, a)) sel = 2'd3;
        end
        return sel;
    endfunction

    function automatic logic src_stall(input logic use_src, input logic [REG_W-1:0] a,
                                       input slot_t es, input slot_t ms, input logic ld_pend);
        return use_src && ((hit(es, a) && es.ld) || (hit(ms, a) && ms.ld && ld_pend));
    endfunction

    // Hazard detection and branch resolution, all same-cycle with ID
    always_comb begin
        ds_slot    = SLOT_EMPTY;
        sel1_c     = 2'd0;
        sel2_c     = 2'd0;
        stall_c    = 1'b0;
        issue      = 1'b0;
        br_resolve = 1'b0;

        ds_slot.v     = 1'b1;
        ds_slot.we    = bus.ds_we;
        ds_slot.waddr = bus.ds_waddr;
        ds_slot.ld    = bus.ds_is_load;

        sel1_c  = pick(bus.ds_use_rj, bus.ds_rj, es_q, ms_q, ws_q);
        sel2_c  = pick(bus.ds_use_rk, bus.ds_rk, es_q, ms_q, ws_q);
        stall_c = bus.ds_valid &&
                  (src_stall(bus.ds_use_rj, bus.ds_rj, es_q, ms_q, bus.ms_load_pending) ||
                   src_stall(bus.ds_use_rk, bus.ds_rk, es_q, ms_q, bus.ms_load_pending));
        issue      = bus.ds_valid && !stall_c && bus.es_allow_in;
        br_resolve = bus.ds_valid && bus.ds_br_taken && !stall_c;
    end

    // Slot chain follows the stage handshakes one edge behind
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_q <= SLOT_EMPTY;
            ms_q <= SLOT_EMPTY;
            ws_q <= SLOT_EMPTY;
        end else begin
            if (issue)           es_q <= ds_slot;
            else if (bus.es_go)  es_q <= SLOT_EMPTY;

            if (bus.es_go)       ms_q <= es_q;
            else if (bus.ms_go)  ms_q <= SLOT_EMPTY;

            if (bus.ms_go)       ws_q <= ms_q;
            else if (bus.ws_go)  ws_q <= SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fl_q <= FL_IDLE;
        else       fl_q <= fl_next;
    end

    // Redirect held until fetch accepts it; acceptance beats a new request
    always_comb begin
        fl_next = fl_q;
        if (bus.fs_ready)     fl_next = FL_IDLE;
        else if (br_resolve)  fl_next = FL_PEND;
    end

    assign bus.ds_stall = stall_c;
    assign bus.fwd_sel1 = sel1_c;
    assign bus.fwd_sel2 = sel2_c;
    assign bus.br_flush = br_resolve || (fl_q == FL_PEND);

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_c && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (br_resolve && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
`else
    assign bus.perf_stall_cnt = CNT_W'(0);
    assign bus.perf_flush_cnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: per-cycle stimulus steps with expected stall/select/flush queued and checked.
module tb_hazard_ctrl;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] rj;
        logic [4:0] rk;
        logic       urj;
        logic       urk;
        logic       we;
        logic [4:0] wa;
        logic       ld;
        logic       br;
        logic       eg;
        logic       mg;
        logic       wg;
        logic       pd;
        logic       fr;
        logic [5:0] ex;   // {stall, sel1, sel2, flush}
    } step_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [5:0] sb[$];

    hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic step_t mk(input logic v, input int rj, input int rk, input logic urj,
                                 input logic urk, input logic we, input int wa, input logic ld,
                                 input logic br, input logic eg, input logic mg, input logic wg,
                                 input logic pd, input logic fr, input logic stall,
                                 input int s1, input int s2, input logic fl);
        step_t s;
        s = '{v:v, rj:5'(rj), rk:5'(rk), urj:urj, urk:urk, we:we, wa:5'(wa), ld:ld, br:br,
              eg:eg, mg:mg, wg:wg, pd:pd, fr:fr, ex:{stall, 2'(s1), 2'(s2), fl}};
        return s;
    endfunction

    task automatic apply(input step_t s);
        bus.ds_valid = s.v;        bus.ds_rj = s.rj;          bus.ds_rk = s.rk;
        bus.ds_use_rj = s.urj;     bus.ds_use_rk = s.urk;     bus.ds_we = s.we;
        bus.ds_waddr = s.wa;       bus.ds_is_load = s.ld;     bus.ds_br_taken = s.br;
        bus.es_go = s.eg;          bus.ms_go = s.mg;          bus.ws_go = s.wg;
        bus.ms_load_pending = s.pd; bus.fs_ready = s.fr;      bus.es_allow_in = 1'b1;
    endtask

    task automatic idle();
        apply(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset = 1'b1;
        idle();
        @(negedge clk);
        #1;
        obs = {bus.ds_stall, bus.fwd_sel1, bus.fwd_sel2, bus.br_flush};
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required %b", obs, 6'b0);
        end
        checks++;
        if (bus.perf_stall_cnt !== '0 || bus.perf_flush_cnt !== '0) begin
            errors++;
            $display("FAIL reset_perf: got stall=%0d flush=%0d required 0/0",
                     bus.perf_stall_cnt, bus.perf_flush_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_forward();
        step_t st[4];
        logic [5:0] e, obs;
        do_reset();
        st[0] = mk(1,0,0,0,0,1,5,0,0, 0,0,0,0,1, 0,0,0,0);
        st[1] = mk(1,5,7,1,1,1,6,0,0, 1,0,0,0,1, 0,1,0,0);
        st[2] = mk(1,5,6,1,1,0,0,0,0, 1,1,0,0,1, 0,2,1,0);
        st[3] = mk(1,5,6,1,1,0,0,0,0, 1,1,1,0,1, 0,3,2,0);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].ex);
            #1;
            e = sb.pop_front();
            obs = {bus.ds_stall, bus.fwd_sel1, bus.fwd_sel2, bus.br_flush};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL forward step %0d: stall/sel1/sel2/flush got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_load_use();
        step_t st[6];
        logic [5:0] e, obs;
        do_reset();
        st[0] = mk(1,0,0,0,0,1,4,1,0, 0,0,0,0,1, 0,0,0,0);
        st[1] = mk(1,0,4,0,1,1,8,0,0, 1,0,0,0,1, 1,0,1,0);
        st[2] = mk(1,0,4,0,1,1,8,0,0, 0,0,0,1,1, 1,0,2,0);
        st[3] = mk(1,0,4,0,1,1,8,0,0, 0,0,0,1,1, 1,0,2,0);
        st[4] = mk(1,0,4,0,1,1,8,0,0, 0,0,0,1,1, 1,0,2,0);
        st[5] = mk(1,0,4,0,1,1,8,0,0, 0,1,0,0,1, 0,0,2,0);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].ex);
            #1;
            e = sb.pop_front();
            obs = {bus.ds_stall, bus.fwd_sel1, bus.fwd_sel2, bus.br_flush};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL load_use step %0d: stall/sel1/sel2/flush got %b required %b", i, obs, e);
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.perf_stall_cnt !== (PERF ? CNT_W'(4) : CNT_W'(0))) begin
            errors++;
            $display("FAIL load_use_perf_stall: got %0d required %0d",
                     bus.perf_stall_cnt, PERF ? 4 : 0);
        end
    endtask

    task automatic test_r0_and_newest();
        step_t st[5];
        logic [5:0] e, obs;
        do_reset();
        st[0] = mk(1,0,0,0,0,1,0,1,0, 0,0,0,0,1, 0,0,0,0);
        st[1] = mk(1,0,0,1,1,1,3,0,0, 1,0,0,0,1, 0,0,0,0);
        st[2] = mk(1,0,0,0,0,1,3,0,0, 1,0,0,0,1, 0,0,0,0);
        st[3] = mk(1,3,0,1,1,0,0,0,0, 0,0,0,0,1, 0,1,0,0);
        st[4] = mk(1,3,3,0,1,0,0,0,0, 1,1,1,0,1, 0,0,2,0);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].ex);
            #1;
            e = sb.pop_front();
            obs = {bus.ds_stall, bus.fwd_sel1, bus.fwd_sel2, bus.br_flush};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL r0_newest step %0d: stall/sel1/sel2/flush got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_branch();
        step_t st[8];
        logic [5:0] e, obs;
        do_reset();
        st[0] = mk(1,0,0,0,0,0,0,0,1, 0,0,0,0,0, 0,0,0,1);
        st[1] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,1);
        st[2] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,1);
        st[3] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,0);
        st[4] = mk(1,0,0,0,0,0,0,0,1, 0,0,0,0,1, 0,0,0,1);
        st[5] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,0);
        st[6] = mk(1,0,0,0,0,1,4,1,0, 0,0,0,0,1, 0,0,0,0);
        st[7] = mk(1,4,0,1,0,0,0,0,1, 0,0,0,0,0, 1,1,0,0);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].ex);
            #1;
            e = sb.pop_front();
            obs = {bus.ds_stall, bus.fwd_sel1, bus.fwd_sel2, bus.br_flush};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL branch step %0d: stall/sel1/sel2/flush got %b required %b", i, obs, e);
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.br_flush !== 1'b0) begin
            errors++;
            $display("FAIL branch_stalled_no_pending: got flush=%b required 0", bus.br_flush);
        end
        checks++;
        if (bus.perf_flush_cnt !== (PERF ? CNT_W'(2) : CNT_W'(0)) ||
            bus.perf_stall_cnt !== (PERF ? CNT_W'(1) : CNT_W'(0))) begin
            errors++;
            $display("FAIL branch_perf: got flush=%0d stall=%0d required %0d/%0d",
                     bus.perf_flush_cnt, bus.perf_stall_cnt, PERF ? 2 : 0, PERF ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid();
        step_t st[2];
        logic [5:0] e, obs;
        do_reset();
        st[0] = mk(1,0,0,0,0,1,4,1,0, 0,0,0,0,1, 0,0,0,0);
        st[1] = mk(1,0,4,0,1,1,9,0,0, 0,0,0,0,1, 1,0,1,0);
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back(st[i].ex);
            #1;
            e = sb.pop_front();
            obs = {bus.ds_stall, bus.fwd_sel1, bus.fwd_sel2, bus.br_flush};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid step %0d: stall/sel1/sel2/flush got %b required %b", i, obs, e);
            end
        end
        #2 reset = 1'b1;
        #1;
        obs = {bus.ds_stall, bus.fwd_sel1, bus.fwd_sel2, bus.br_flush};
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_async_drop: got %b required %b", obs, 6'b0);
        end
        checks++;
        if (bus.perf_stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_async_perf: got %0d required 0", bus.perf_stall_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        obs = {bus.ds_stall, bus.fwd_sel1, bus.fwd_sel2, bus.br_flush};
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_slots_empty: got %b required %b", obs, 6'b0);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_r0_and_newest();
        test_branch();
        test_reset_mid();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
